// File: rtl/ex_stage_div_pkg.sv
// Shared EX-stage definitions: bus widths, opcode bit positions,
// divider states and the packed ID->EX / EX->MEM / forwarding bundles.
package ex_stage_div_pkg;

  localparam int DS_TO_ES_BUS_WD = 159;
  localparam int ES_TO_MS_BUS_WD = 76;
  localparam int ES_FW_BUS_WD    = 39;

  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_SLT  = 2;
  localparam int ALU_SLTU = 3;
  localparam int ALU_AND  = 4;
  localparam int ALU_NOR  = 5;
  localparam int ALU_OR   = 6;
  localparam int ALU_XOR  = 7;
  localparam int ALU_SLL  = 8;
  localparam int ALU_SRL  = 9;
  localparam int ALU_SRA  = 10;
  localparam int ALU_LUI  = 11;

  localparam int DIV_W  = 0;
  localparam int MOD_W  = 1;
  localparam int DIV_WU = 2;
  localparam int MOD_WU = 3;

  localparam int LD_B  = 0;
  localparam int LD_H  = 1;
  localparam int LD_W  = 2;
  localparam int LD_BU = 3;
  localparam int LD_HU = 4;

  localparam int ST_B = 0;
  localparam int ST_H = 1;
  localparam int ST_W = 2;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  typedef struct packed {
    logic [11:0] alu_op;
    logic [3:0]  div_op;
    logic [4:0]  load_op;
    logic [2:0]  store_op;
    logic [31:0] pc;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] rkd_value;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
  } ds_es_t;

  typedef struct packed {
    logic [4:0]  load_op;
    logic [31:0] pc;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
  } es_ms_t;

  typedef struct packed {
    logic        we_valid;
    logic        ld_valid;
    logic [4:0]  dest;
    logic [31:0] result;
  } es_fw_t;

  function automatic logic [31:0] mag(input logic [31:0] v,
                                      input logic sgn);
    return (sgn & v[31]) ? -v : v;
  endfunction

endpackage

// File: rtl/ex_stage_div_div.sv
// Radix-2 restoring divider: latches magnitudes and result signs,
// iterates DIV_ITER cycles, then holds the selected result until ack.
module es_div
  import ex_stage_div_pkg::*;
#(
  parameter int DIV_ITER = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  div_op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        ack,
  output logic        done,
  output logic [31:0] result
);

  localparam int CW = $clog2(DIV_ITER + 1);

  div_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rem_q, rem_d;
  logic [31:0]   quo_q, quo_d;
  logic [31:0]   dvs_q, dvs_d;
  logic          qneg_q, qneg_d;
  logic          rneg_q, rneg_d;

  logic        sgn;
  logic [32:0] part;
  logic [32:0] diff;

  assign sgn  = div_op[DIV_W] | div_op[MOD_W];
  assign part = {rem_q, quo_q[31]};
  assign diff = part - {1'b0, dvs_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    unique case (state_q)
      DIV_IDLE: begin
        if (start) begin
          state_d = DIV_CALC;
          cnt_d   = '0;
          rem_d   = '0;
          quo_d   = mag(src1, sgn);
          dvs_d   = mag(src2, sgn);
          // x/0 keeps the all-ones quotient unsigned
          qneg_d  = sgn & (src1[31] ^ src2[31]) & (|src2);
          rneg_d  = sgn & src1[31];
        end
      end
      DIV_CALC: begin
        if (!diff[32]) begin
          rem_d = diff[31:0];
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = part[31:0];
          quo_d = {quo_q[30:0], 1'b0};
        end
        if (cnt_q == CW'(DIV_ITER - 1)) begin
          state_d = DIV_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DIV_DONE: begin
        if (ack) begin
          state_d = DIV_IDLE;
        end
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

  logic [31:0] q_fin;
  logic [31:0] r_fin;

  assign q_fin  = qneg_q ? -quo_q : quo_q;
  assign r_fin  = rneg_q ? -rem_q : rem_q;
  assign done   = (state_q == DIV_DONE);
  assign result = (div_op[MOD_W] | div_op[MOD_WU]) ? r_fin : q_fin;

endmodule

// File: rtl/ex_stage_div.sv
// Execute stage: ID->EX register, inline one-hot ALU, multi-cycle
// divider, data_sram request generation and forwarding bus to ID.
module ex_stage_div
  import ex_stage_div_pkg::*;
#(
  parameter int DIV_ITER = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ds_to_es_valid,
  input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
  output logic                       es_allowin,
  input  logic                       ms_allowin,
  output logic                       es_to_ms_valid,
  output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic [ES_FW_BUS_WD-1:0]    es_fw_bus,
  output logic                       data_sram_en,
  output logic [3:0]                 data_sram_we,
  output logic [31:0]                data_sram_addr,
  output logic [31:0]                data_sram_wdata
);

  logic   es_valid_q, es_valid_d;
  ds_es_t bus_q, bus_d;

  logic        es_ready_go;
  logic        is_div;
  logic        div_done;
  logic [31:0] div_res;
  logic [31:0] alu_res;
  logic [31:0] result;
  logic [31:0] add_sum;
  logic [4:0]  sa;

  assign is_div         = |bus_q.div_op;
  assign es_ready_go    = ~is_div | div_done;
  assign es_allowin     = ~es_valid_q | (es_ready_go & ms_allowin);
  assign es_to_ms_valid = es_valid_q & es_ready_go;

  always_comb begin
    es_valid_d = es_valid_q;
    bus_d      = bus_q;
    if (es_allowin) begin
      es_valid_d = ds_to_es_valid;
    end
    if (es_allowin & ds_to_es_valid) begin
      bus_d = ds_es_t'(ds_to_es_bus);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      es_valid_q <= 1'b0;
      bus_q      <= '0;
    end else begin
      es_valid_q <= es_valid_d;
      bus_q      <= bus_d;
    end
  end

  es_div #(
    .DIV_ITER(DIV_ITER)
  ) u_div (
    .clk   (clk),
    .reset (reset),
    .start (es_valid_q & is_div),
    .div_op(bus_q.div_op),
    .src1  (bus_q.src1),
    .src2  (bus_q.src2),
    .ack   (es_to_ms_valid & ms_allowin),
    .done  (div_done),
    .result(div_res)
  );

  assign add_sum = bus_q.src1 + bus_q.src2;
  assign sa      = bus_q.src2[4:0];

  always_comb begin
    alu_res = '0;
    unique case (1'b1)
      bus_q.alu_op[ALU_ADD]:  alu_res = add_sum;
      bus_q.alu_op[ALU_SUB]:  alu_res = bus_q.src1 - bus_q.src2;
      bus_q.alu_op[ALU_SLT]:
        alu_res = {31'd0, $signed(bus_q.src1) < $signed(bus_q.src2)};
      bus_q.alu_op[ALU_SLTU]:
        alu_res = {31'd0, bus_q.src1 < bus_q.src2};
      bus_q.alu_op[ALU_AND]:  alu_res = bus_q.src1 & bus_q.src2;
      bus_q.alu_op[ALU_NOR]:  alu_res = ~(bus_q.src1 | bus_q.src2);
      bus_q.alu_op[ALU_OR]:   alu_res = bus_q.src1 | bus_q.src2;
      bus_q.alu_op[ALU_XOR]:  alu_res = bus_q.src1 ^ bus_q.src2;
      bus_q.alu_op[ALU_SLL]:  alu_res = bus_q.src1 << sa;
      bus_q.alu_op[ALU_SRL]:  alu_res = bus_q.src1 >> sa;
      bus_q.alu_op[ALU_SRA]:
        alu_res = 32'($signed(bus_q.src1) >>> sa);
      bus_q.alu_op[ALU_LUI]:  alu_res = bus_q.src2;
      default:                alu_res = '0;
    endcase
  end

  assign result = is_div ? div_res : alu_res;

  logic [31:0] rkd;
  assign rkd = bus_q.rkd_value;

  always_comb begin
    data_sram_we    = '0;
    data_sram_wdata = rkd;
    unique case (1'b1)
      bus_q.store_op[ST_B]: begin
        data_sram_we    = 4'b0001 << result[1:0];
        data_sram_wdata = {4{rkd[7:0]}};
      end
      bus_q.store_op[ST_H]: begin
        data_sram_we    = 4'b0011 << {result[1], 1'b0};
        data_sram_wdata = {2{rkd[15:0]}};
      end
      bus_q.store_op[ST_W]: data_sram_we = 4'b1111;
      default:              data_sram_we = '0;
    endcase
    if (!es_valid_q) begin
      data_sram_we = '0;
    end
  end

  assign data_sram_en = es_valid_q & ms_allowin
                      & ((|bus_q.load_op) | (|bus_q.store_op));
  assign data_sram_addr = result;

  es_ms_t ms_out;
  es_fw_t fw_out;

  always_comb begin
    ms_out.load_op      = bus_q.load_op;
    ms_out.pc           = bus_q.pc;
    ms_out.res_from_mem = bus_q.res_from_mem;
    ms_out.gr_we        = bus_q.gr_we;
    ms_out.dest         = bus_q.dest;
    ms_out.result       = result;
    fw_out.we_valid     = es_valid_q & bus_q.gr_we;
    fw_out.ld_valid     = es_valid_q & bus_q.res_from_mem;
    fw_out.dest         = bus_q.dest;
    fw_out.result       = result;
  end

  assign es_to_ms_bus = ms_out;
  assign es_fw_bus    = fw_out;

endmodule
